ika32010_ioport: RTL

- I/O port bridge directly downstream of the IKA32010 controller's external bus; services the DSP's IN/OUT port cycles (port address = AOUT[2:0]).
- OUT cycles (WE_n strobe) are queued into a FIFO toward a host.
- IN cycles (DEN_n strobe) are answered from eight host-loaded input registers, each with a mailbox-full flag; one flag drives the controller's BIO_n pin.

---
 rtl/ika32010_ioport.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ika32010_ioport.sv
// ----------------------------------------------------------------------------
// ika32010_ioport
//
// I/O port bridge sitting on the IKA32010 controller's external bus. It
// services the DSP's port cycles, where the port number is AOUT[2:0]:
//   * OUT cycles (WE_n low) are captured and queued into a FIFO toward a host.
//   * IN cycles (DEN_n low) are answered from eight host-loaded input
//     registers. Each register has a mailbox-full flag, and one of these flags
//     drives the controller's BIO_n pin.
//
// Parameters
//   FIFO_DEPTH : number of output FIFO entries (power of two, 2..64)
//   BIO_PORT   : input port (0..7) whose full flag drives o_BIO_n
//
// Build option
//   IKA32010_IOPORT_STATUS_EN : when defined, a DSP read of port 7 returns
//   {o_OVF, 1'b0, o_FIFO_CNT[5:0], full[7:0]} instead of the port-7 register,
//   and completing a port-7 read leaves full[7] unchanged. When the macro is
//   not defined, port 7 behaves like ports 0..6.
//
// Ports
//   i_EMUCLK       system clock; all logic runs on its rising edge
//   i_RST          synchronous reset, active high
//   i_DEN_n        controller data-read strobe (multi-cycle, active low)
//   i_WE_n         controller write strobe (multi-cycle, active low)
//   i_AOUT[2:0]    port address
//   i_DOUT[15:0]   controller write data
//   o_DIN[15:0]    read data to the controller; zero when not reading
//   o_DIN_OE       high while o_DIN is driven
//   o_BIO_n        low while full[BIO_PORT] is set, one cycle behind the flag
//   o_HOST_VALID   FIFO head is valid
//   o_HOST_PORT    port number of the FIFO head
//   o_HOST_DATA    data of the FIFO head
//   i_HOST_READY   pops the FIFO head when o_HOST_VALID is high
//   i_HOST_WR      loads an input register and sets its full flag
//   i_HOST_WPORT   selects the input register to load
//   i_HOST_WDATA   data for the input register
//   o_FIFO_CNT     FIFO occupancy, 0..FIFO_DEPTH
//   o_OVF          sticky overflow; cleared only by reset
// ----------------------------------------------------------------------------
module ika32010_ioport #(
    parameter int FIFO_DEPTH = 8,
    parameter int BIO_PORT   = 0
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_DEN_n,
    input  logic        i_WE_n,
    input  logic [2:0]  i_AOUT,
    input  logic [15:0] i_DOUT,
    output logic [15:0] o_DIN,
    output logic        o_DIN_OE,
    output logic        o_BIO_n,
    output logic        o_HOST_VALID,
    output logic [2:0]  o_HOST_PORT,
    output logic [15:0] o_HOST_DATA,
    input  logic        i_HOST_READY,
    input  logic        i_HOST_WR,
    input  logic [2:0]  i_HOST_WPORT,
    input  logic [15:0] i_HOST_WDATA,
    output logic [6:0]  o_FIFO_CNT,
    output logic        o_OVF
);

    localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0]       DEPTH_C = 7'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [2:0]       BIO_IDX = 3'(BIO_PORT);

`ifdef IKA32010_IOPORT_STATUS_EN
    // Port 7 is the status port; its read completion must not consume full[7].
    localparam logic [7:0] CLR_MASK = 8'h7F;
`else
    localparam logic [7:0] CLR_MASK = 8'hFF;
`endif

    // ------------------------------------------------------------------------
    // Strobe trackers and write capture
    // ------------------------------------------------------------------------
    logic        we_q;
    logic        den_q;
    logic [2:0]  hold_port_q;
    logic [15:0] hold_data_q;
    logic [2:0]  rd_port_q;

    // Rising edge of each strobe. The trackers reset to "high", so a strobe
    // that was already low during reset only counts once a low cycle has been
    // sampled after reset is released.
    logic wr_commit;
    logic rd_done;

    assign wr_commit = ~we_q & i_WE_n;
    assign rd_done   = ~den_q & i_DEN_n;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            we_q        <= 1'b1;
            den_q       <= 1'b1;
            hold_port_q <= 3'd0;
            hold_data_q <= 16'd0;
            rd_port_q   <= 3'd0;
        end else begin
            we_q  <= i_WE_n;
            den_q <= i_DEN_n;
            // The bus may still be settling early in the strobe, so the last
            // value sampled while low is the one that gets committed.
            if (!i_WE_n) begin
                hold_port_q <= i_AOUT;
                hold_data_q <= i_DOUT;
            end
            if (!i_DEN_n) begin
                rd_port_q <= i_AOUT;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO: storage array plus a registered show-ahead head
    // ------------------------------------------------------------------------
    logic [18:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [6:0]       cnt_q;
    logic [6:0]       cnt_d;
    logic             valid_q;
    logic [2:0]       head_port_q;
    logic [15:0]      head_data_q;
    logic             ovf_q;

    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        bypass;
    logic [18:0] push_entry;

    assign fifo_full  = (cnt_q == DEPTH_C);
    assign pop        = valid_q & i_HOST_READY;
    // Popping frees a slot in the same cycle, so a push at full is legal then.
    assign push       = wr_commit & (~fifo_full | pop);
    assign drop       = wr_commit & fifo_full & ~pop;
    assign push_entry = {hold_port_q, hold_data_q};

    // The entry being pushed becomes the head right away when it lands in the
    // slot the head pointer moves to: an empty FIFO, or a single entry that is
    // popped in the same cycle. Otherwise the head is read from the array.
    assign bypass = push & ((cnt_q == 7'd0) | ((cnt_q == 7'd1) & pop));

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 7'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 7'd1;
        end
    end

    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // Storage array, no reset so it maps onto memory resources.
    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= 7'd0;
            valid_q     <= 1'b0;
            head_port_q <= 3'd0;
            head_data_q <= 16'd0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= (cnt_d != 7'd0);
            if (drop) begin
                ovf_q <= 1'b1;
            end
            // Registered read at the next head pointer gives show-ahead
            // behaviour with no bubble between back-to-back pops. The write
            // slot never equals rd_ptr_d outside the bypass cases.
            if (cnt_d == 7'd0) begin
                head_port_q <= 3'd0;
                head_data_q <= 16'd0;
            end else if (bypass) begin
                {head_port_q, head_data_q} <= push_entry;
            end else begin
                {head_port_q, head_data_q} <= fifo_mem[rd_ptr_d];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Input registers and mailbox-full flags
    // ------------------------------------------------------------------------
    logic [15:0] inreg_q [8];
    logic [7:0]  full_q;
    logic [7:0]  full_d;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            for (int i = 0; i < 8; i++) begin
                inreg_q[i] <= 16'd0;
            end
        end else if (i_HOST_WR) begin
            inreg_q[i_HOST_WPORT] <= i_HOST_WDATA;
        end
    end

    // A host load wins over a read completion on the same port, so a fresh
    // value delivered just as the DSP finishes reading is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_full
            logic set_flag;
            logic clr_flag;
            assign set_flag   = i_HOST_WR & (i_HOST_WPORT == 3'(gi));
            assign clr_flag   = rd_done & (rd_port_q == 3'(gi)) & CLR_MASK[gi];
            assign full_d[gi] = set_flag ? 1'b1 : (clr_flag ? 1'b0 : full_q[gi]);
        end
    endgenerate

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            full_q <= 8'd0;
        end else begin
            full_q <= full_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read path: one cycle of latency from the falling DEN_n
    // ------------------------------------------------------------------------
    logic [15:0] rd_word;
    logic [15:0] din_q;
    logic        din_oe_q;
    logic        bio_n_q;

    always_comb begin
        rd_word = inreg_q[i_AOUT];
`ifdef IKA32010_IOPORT_STATUS_EN
        if (i_AOUT == 3'd7) begin
            rd_word = {ovf_q, 1'b0, cnt_q[5:0], full_q};
        end
`endif
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            din_q    <= 16'd0;
            din_oe_q <= 1'b0;
            bio_n_q  <= 1'b1;
        end else begin
            din_oe_q <= ~i_DEN_n;
            din_q    <= i_DEN_n ? 16'd0 : rd_word;
            bio_n_q  <= ~full_q[BIO_IDX];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_DIN        = din_q;
    assign o_DIN_OE     = din_oe_q;
    assign o_BIO_n      = bio_n_q;
    assign o_HOST_VALID = valid_q;
    assign o_HOST_PORT  = head_port_q;
    assign o_HOST_DATA  = head_data_q;
    assign o_FIFO_CNT   = cnt_q;
    assign o_OVF        = ovf_q;

endmodule
